// File: rtl/dm_access_ctrl.sv
// Data-memory access sequencer: IDLE -> ACCESS (req/ack, bounded wait) -> DONE.
// Legal loads/stores stall the pipeline until DONE; faulting addresses raise AdEL/AdES and are never issued.
module dm_access_ctrl #(
  parameter logic [31:0] DM_BASE = 32'h0000_0000,
  parameter logic [31:0] DM_SIZE = 32'h0000_3000,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  Op_M,
  input  logic [31:0] Addr_M,
  input  logic [31:0] WData_M,
  output logic        Stall_M,
  output logic [31:0] RData_M,
  output logic        AdEL,
  output logic        AdES,
  output logic        BusErr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [5:0]    op_q;
  logic [1:0]    lo_q;
  logic [31:0]   rdata_q;
  logic          buserr_q;
  logic          req_q;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;

  logic        is_ld, is_st, need_h, need_w;
  logic        misalign, in_range, fault, idle, go;
  logic [32:0] off;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ext_d;

  always_comb begin
    is_ld  = 1'b0;
    is_st  = 1'b0;
    need_h = 1'b0;
    need_w = 1'b0;
    case (Op_M)
      OP_LB, OP_LBU: is_ld = 1'b1;
      OP_LH, OP_LHU: begin is_ld = 1'b1; need_h = 1'b1; end
      OP_LW:         begin is_ld = 1'b1; need_w = 1'b1; end
      OP_SB:         is_st = 1'b1;
      OP_SH:         begin is_st = 1'b1; need_h = 1'b1; end
      OP_SW:         begin is_st = 1'b1; need_w = 1'b1; end
      default:       ;
    endcase
  end

  // Range check via offset from base; the borrow bit flags addresses below DM_BASE.
  assign off      = {1'b0, Addr_M} - {1'b0, DM_BASE};
  assign in_range = ~off[32] && (off[31:0] < DM_SIZE);
  assign misalign = (need_h & Addr_M[0]) | (need_w & (|Addr_M[1:0]));
  assign fault    = misalign | ~in_range;
  assign idle     = (state_q == S_IDLE);
  assign go       = idle & (is_ld | is_st) & ~fault;

  assign AdEL    = idle & is_ld & fault;
  assign AdES    = idle & is_st & fault;
  assign Stall_M = go | (state_q == S_ACCESS);

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = 32'h0;
    case (Op_M)
      OP_SB: begin
        be_d    = 4'b0001 << Addr_M[1:0];
        wdata_d = {4{WData_M[7:0]}};
      end
      OP_SH: begin
        be_d    = Addr_M[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{WData_M[15:0]}};
      end
      OP_SW:   wdata_d = WData_M;
      default: ;
    endcase
  end

  // Lane selection uses the latched low address bits, not the live ALU output.
  always_comb begin
    case (lo_q)
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (op_q)
      OP_LB:   ext_d = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  ext_d = {24'h0, byte_sel};
      OP_LH:   ext_d = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  ext_d = {16'h0, half_sel};
      OP_LW:   ext_d = mem_rdata;
      default: ext_d = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= 6'h0;
      lo_q     <= 2'b00;
      rdata_q  <= 32'h0;
      buserr_q <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'h0;
      be_q     <= 4'h0;
      wdata_q  <= 32'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (go) begin
            addr_q  <= {Addr_M[31:2], 2'b00};
            we_q    <= is_st;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            op_q    <= Op_M;
            lo_q    <= Addr_M[1:0];
            cnt_q   <= '0;
            req_q   <= 1'b1;
            state_q <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (mem_ack) begin
            rdata_q <= ext_d;
            req_q   <= 1'b0;
            state_q <= S_DONE;
          end else if (cnt_q == CNT_LAST) begin
            rdata_q  <= 32'h0;
            buserr_q <= 1'b1;
            req_q    <= 1'b0;
            state_q  <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          buserr_q <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign RData_M   = rdata_q;
  assign BusErr    = buserr_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;

endmodule
